// File: rtl/tri_pkg.sv
// Shared types and constants for the rasterizer triangle streamer.
// The vertex layout puts x in the most significant field.
package tri_pkg;

  localparam int COORD_W = 9;

  typedef logic [2:0][COORD_W-1:0] vertex_t;

  localparam int X_IDX = 2;
  localparam int Y_IDX = 1;
  localparam int Z_IDX = 0;

  // Return tags: 0 marks the index-table read, 1..3 the vertex slots.
  typedef logic [1:0] slot_t;
  localparam slot_t SLOT_IDX = 2'd0;
  localparam slot_t SLOT_V3  = 2'd3;

  typedef struct packed {
    logic  valid;
    slot_t tag;
  } lat_ent_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_IDX,
    WAIT_IDX,
    FETCH_VERT,
    WAIT_VERT,
    PRESENT,
    DONE
  } tri_state_t;

endpackage

// File: rtl/rd_lat_pipe.sv
// Tracks outstanding reads to a fixed-latency synchronous memory and
// raises a tagged strobe in the cycle the matching data is on the bus.
module rd_lat_pipe
  import tri_pkg::*;
#(
  parameter int READ_LAT = 2
) (
  input  logic  clk_in,
  input  logic  rst_in,
  input  logic  issue_in,
  input  slot_t tag_in,
  output logic  ret_valid_out,
  output slot_t ret_tag_out
);

  lat_ent_t stage_q [READ_LAT];

  // NOTE: this shift register is reset, unlike a data RAM, so a read that
  // was in flight when reset hit can never surface afterwards as a return.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < READ_LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= '{valid: issue_in, tag: tag_in};
      for (int i = 1; i < READ_LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign ret_valid_out = stage_q[READ_LAT-1].valid;
  assign ret_tag_out   = stage_q[READ_LAT-1].tag;

endmodule

// File: rtl/tri_streamer.sv
// Transmit side of the rasterizer triangle interface: walks the index and
// vertex tables and presents one triangle at a time with valid/ready.
module tri_streamer #(
  parameter int NUM_TRIS  = 12,
  parameter int NUM_VERTS = 8,
  parameter int COORD_W   = 9,
  parameter int READ_LAT  = 2,
  localparam int TCW      = (NUM_TRIS > 1) ? $clog2(NUM_TRIS) : 1,
  localparam int VAW      = $clog2(NUM_VERTS)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      frame_start_in,
  input  logic                      tri_ready_in,
  output logic [TCW-1:0]            idx_addr_out,
  input  logic [3*VAW-1:0]          idx_data_in,
  output logic [VAW-1:0]            vert_addr_out,
  input  logic [3*COORD_W-1:0]      vert_data_in,
  output logic [2:0][COORD_W-1:0]   vert1_out,
  output logic [2:0][COORD_W-1:0]   vert2_out,
  output logic [2:0][COORD_W-1:0]   vert3_out,
  output logic                      valid_tri_out,
  output logic                      obj_done_out,
  output logic                      busy_out
);

  import tri_pkg::*;

  tri_state_t state_q, state_d;

  logic [TCW-1:0]            tri_cnt_q;
  logic [1:0]                vcnt_q;
  logic [3*VAW-1:0]          idx_q;
  logic [VAW-1:0]            vert_addr_q;
  logic [2:0][COORD_W-1:0]   vert_word;
  logic [2:0][COORD_W-1:0]   stage1_q, stage2_q;
  logic [2:0][COORD_W-1:0]   v1_q, v2_q, v3_q;

  logic  idx_ret_valid, vert_ret_valid;
  slot_t idx_ret_tag, vert_ret_tag;
  logic  idx_ret, last_tri, transfer;

  rd_lat_pipe #(.READ_LAT(READ_LAT)) u_idx_pipe (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .issue_in      (state_q == FETCH_IDX),
    .tag_in        (SLOT_IDX),
    .ret_valid_out (idx_ret_valid),
    .ret_tag_out   (idx_ret_tag)
  );

  rd_lat_pipe #(.READ_LAT(READ_LAT)) u_vert_pipe (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .issue_in      (state_q == FETCH_VERT),
    .tag_in        (vcnt_q + 2'd1),
    .ret_valid_out (vert_ret_valid),
    .ret_tag_out   (vert_ret_tag)
  );

  assign idx_ret  = idx_ret_valid && (idx_ret_tag == SLOT_IDX);
  assign last_tri = (tri_cnt_q == TCW'(NUM_TRIS - 1));
  assign transfer = (state_q == PRESENT) && tri_ready_in;

  always_comb begin
    vert_word        = '0;
    vert_word[X_IDX] = vert_data_in[3*COORD_W-1 -: COORD_W];
    vert_word[Y_IDX] = vert_data_in[2*COORD_W-1 -: COORD_W];
    vert_word[Z_IDX] = vert_data_in[COORD_W-1:0];
  end

  // NOTE: every register uses <= so all flops update together at the edge;
  // blocking assignments here would make later reads see same-cycle values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (frame_start_in) state_d = FETCH_IDX;
      FETCH_IDX:  state_d = WAIT_IDX;
      WAIT_IDX:   if (idx_ret) state_d = FETCH_VERT;
      FETCH_VERT: if (vcnt_q == 2'd2) state_d = WAIT_VERT;
      WAIT_VERT:  if (vert_ret_valid && vert_ret_tag == SLOT_V3) state_d = PRESENT;
      PRESENT:    if (tri_ready_in) state_d = last_tri ? DONE : FETCH_IDX;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_tri_out = 1'b0;
    obj_done_out  = 1'b0;
    busy_out      = 1'b1;
    unique case (state_q)
      IDLE:    busy_out      = 1'b0;
      PRESENT: valid_tri_out = 1'b1;
      DONE:    obj_done_out  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tri_cnt_q   <= '0;
      vcnt_q      <= '0;
      idx_q       <= '0;
      vert_addr_q <= '0;
      stage1_q    <= '0;
      stage2_q    <= '0;
      v1_q        <= '0;
      v2_q        <= '0;
      v3_q        <= '0;
    end else begin
      if (state_q == IDLE && frame_start_in) tri_cnt_q <= '0;
      else if (transfer && !last_tri)        tri_cnt_q <= tri_cnt_q + TCW'(1);

      vcnt_q <= (state_q == FETCH_VERT) ? vcnt_q + 2'd1 : 2'd0;

      // i1 goes out straight from the returning word; i2/i3 from the copy.
      if (idx_ret) begin
        idx_q       <= idx_data_in;
        vert_addr_q <= idx_data_in[VAW-1:0];
      end else if (state_q == FETCH_VERT) begin
        if (vcnt_q == 2'd0)      vert_addr_q <= idx_q[VAW +: VAW];
        else if (vcnt_q == 2'd1) vert_addr_q <= idx_q[2*VAW +: VAW];
      end

      // Outputs change only when the whole triangle is in, so they hold
      // the previous triangle until the new valid window opens.
      if (vert_ret_valid) begin
        unique case (vert_ret_tag)
          2'd1: stage1_q <= vert_word;
          2'd2: stage2_q <= vert_word;
          2'd3: begin
            v1_q <= stage1_q;
            v2_q <= stage2_q;
            v3_q <= vert_word;
          end
          default: ;
        endcase
      end
    end
  end

  assign idx_addr_out  = tri_cnt_q;
  assign vert_addr_out = vert_addr_q;
  assign vert1_out     = v1_q;
  assign vert2_out     = v2_q;
  assign vert3_out     = v3_q;

endmodule

// File: doc/tri_streamer.md
Name: tri_streamer

Overview:
- Transmit side of the rasterizer triangle interface.
- On each frame start, walks a triangle index table and a vertex table, both held in external synchronous-read memories.
- Presents one triangle at a time as three vertices with a valid/ready handshake toward the rasterizer.
- Pulses obj_done after the last triangle of the object has been accepted.

Parameters:
- NUM_TRIS, 12, triangles per object (>=1).
- NUM_VERTS, 8, entries in the vertex table (>=3).
- COORD_W, 9, bits per vertex coordinate.
- READ_LAT, 2, cycles from address to data on both memory ports (>=1).

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-low reset.
- frame_start_in  in  1  single-cycle pulse; begin streaming the object.
- tri_ready_in  in  1  rasterizer can accept a triangle.
- idx_addr_out  out  $clog2(NUM_TRIS)  triangle index table address.
- idx_data_in  in  3*$clog2(NUM_VERTS)  packed vertex indices {i3,i2,i1}.
- vert_addr_out  out  $clog2(NUM_VERTS)  vertex table address.
- vert_data_in  in  3*COORD_W  packed {x,y,z}; x in the MS field.
- vert1_out, vert2_out, vert3_out  out  [2:0][COORD_W-1:0]  vertex triples; [2]=x, [1]=y, [0]=z.
- valid_tri_out  out  1  triangle outputs are valid.
- obj_done_out  out  1  one-cycle pulse after the final triangle is accepted.
- busy_out  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_in low, asynchronous):
  - All outputs go to 0 and the FSM returns to IDLE.
  - Any triangle in flight is abandoned; no obj_done pulse is issued.
  - Streaming resumes only on a new frame_start_in after rst_in is deasserted.
- FSM states: IDLE, FETCH_IDX, WAIT_IDX, FETCH_VERT, WAIT_VERT, PRESENT, DONE.
- IDLE:
  - frame_start_in=1 clears tri_cnt to 0 and goes to FETCH_IDX.
  - frame_start_in is ignored in every other state, including DONE.
- FETCH_IDX (1 cycle, cycle T):
  - idx_addr_out=tri_cnt.
  - Goes to WAIT_IDX.
- WAIT_IDX:
  - idx_data_in is captured at T+READ_LAT.
  - Goes to FETCH_VERT.
- FETCH_VERT (3 cycles, T+READ_LAT+1..+3):
  - vert_addr_out drives i1, then i2, then i3 on consecutive cycles.
  - A sub-module tracks the READ_LAT delay and tags each return as slot 1, 2 or 3.
- WAIT_VERT:
  - Returned data is captured into vertN registers in tag order.
  - After slot 3 is captured, goes to PRESENT.
- PRESENT:
  - valid_tri_out=1 from cycle T+2*READ_LAT+4 (T+8 at the defaults).
  - vert*_out are registered and stay stable while valid_tri_out=1 and tri_ready_in=0.
  - Transfer occurs on the cycle where valid_tri_out=1 and tri_ready_in=1.
  - On transfer: valid_tri_out drops the next cycle.
  - On transfer with tri_cnt<NUM_TRIS-1: tri_cnt increments and the FSM goes to FETCH_IDX. There is no prefetch, so per-triangle throughput is 2*READ_LAT+5 cycles minimum.
  - On transfer with tri_cnt=NUM_TRIS-1: goes to DONE.
- DONE (1 cycle):
  - obj_done_out=1.
  - Goes to IDLE.
- Between valid windows, vert*_out hold the last values.
- tri_ready_in is a don't-care outside PRESENT.
- idx_addr_out and vert_addr_out hold their last value when not fetching.
- Index values >= NUM_VERTS are passed to the address port unchanged; the block does not check them.
- Width rules:
  - No arithmetic is applied to coordinates; they pass through bit-exact.
  - tri_cnt is $clog2(NUM_TRIS) bits wide.
  - With NUM_TRIS=1, tri_cnt is held at 0 and the FSM goes straight to DONE after the first transfer.

Decomposition:
- Package tri_pkg holds:
  - COORD_W.
  - typedef vertex_t as a packed [2:0][COORD_W-1:0].
  - Vertex field index constants X_IDX=2, Y_IDX=1, Z_IDX=0.
  - The tri_state_t enum.
- Sub-module rd_lat_pipe:
  - A READ_LAT-deep shift register of {valid, 2-bit slot tag}.
  - Input: the issue strobe and tag. Output: the matching data-valid strobe and tag.
  - The same sub-module is used for the index return as tag 0.

Test Plan:
- Reset values:
  - Stimulus: hold rst_in=0 for 3 cycles, release.
  - Required: all outputs 0, busy_out=0, no memory address activity until frame_start_in.
- Single triangle, no backpressure:
  - Stimulus: NUM_TRIS=1; idx ROM[0]={2,1,0}; vert ROM[0]={20,20,0}, ROM[1]={20,40,0}, ROM[2]={40,20,0}; tri_ready_in=1; frame_start_in at T-1.
  - Required: valid_tri_out=1 at exactly T+8 for one cycle with vert1_out={20,20,0}, vert2_out={20,40,0}, vert3_out={40,20,0}; obj_done_out pulses at T+9.
- Backpressure:
  - Stimulus: NUM_TRIS=2; tri_ready_in=0 for 5 cycles after valid rises, then 1.
  - Required: outputs bit-stable for all 6 cycles; triangle 1 is fetched next; exactly 2 transfers and 1 obj_done pulse.
- Ignored restart:
  - Stimulus: frame_start_in pulses during WAIT_VERT and during DONE.
  - Required: no restart, tri_cnt unaffected, busy_out=0 after DONE.
- Reset mid-operation:
  - Stimulus: rst_in=0 while valid_tri_out=1.
  - Required: valid_tri_out=0 asynchronously in the same cycle; no obj_done_out; a new frame_start_in restarts from triangle 0.
- Back-to-back frames:
  - Stimulus: NUM_TRIS=12; frame_start_in the cycle after obj_done_out.
  - Required: 24 transfers in index order 0..11, 0..11, with 2 obj_done pulses.
